// File: rtl/exp2_fixed.sv
// ---------------------------------------------------------------------------
// exp2_fixed
//
// Sequential fixed-point base-2 exponentiator: y = 2^x.
//
// x is split into a signed integer part n = floor(x) and a non-negative
// fraction f. The fraction is turned into a mantissa m = 2^f in Q2.30 by
// multiplying 1.0 by C_i = 2^(2^-i) for every set bit of f. The work is one
// bit per clock, starting at the MSB. The integer part is then applied as a
// binary shift that also rescales m from 30 to Y_FRAC fractional bits.
//
// Optional build macro:
//   EXP2_ROUND_EN  - final right shift rounds half-up instead of truncating.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous reset, active-low
//   in_valid   in   x is valid
//   in_ready   out  block can accept x (only while idle)
//   in_x       in   signed x, Q(X_INT).(X_FRAC) two's complement
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes the result
//   out_y      out  unsigned y, Q(Y_WIDTH-Y_FRAC).(Y_FRAC)
//   out_ovf    out  result saturated to all ones (qualified by out_valid)
// ---------------------------------------------------------------------------
module exp2_fixed #(
  parameter int X_INT   = 6,
  parameter int X_FRAC  = 16,
  parameter int Y_WIDTH = 32,
  parameter int Y_FRAC  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [X_INT+X_FRAC-1:0] in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [Y_WIDTH-1:0]      out_y,
  output logic                    out_ovf
);

  localparam int XW     = X_INT + X_FRAC;
  localparam int M_FRAC = 30;
  localparam int CNT_W  = $clog2(X_FRAC + 1);
  // Room for a 32-bit mantissa shifted left by up to 63 bits.
  localparam int WIDE_W = 96;
  localparam logic [31:0] M_ONE = 32'h4000_0000;

  // Builds the packed table of C_i = round(2^(2^-i) * 2^30), i = 1..X_FRAC.
  // Entry i lives in bits [(i-1)*32 +: 32]. Evaluated once at elaboration.
  function automatic logic [X_FRAC*32-1:0] build_table();
    logic [X_FRAC*32-1:0] tab;
    real                  e;
    real                  c;
    tab = '0;
    for (int i = 1; i <= X_FRAC; i++) begin
      e = 1.0;
      for (int k = 0; k < i; k++) begin
        e = e / 2.0;
      end
      c = (2.0 ** e) * 1073741824.0 + 0.5;
      tab[(i-1)*32 +: 32] = 32'($rtoi(c));
    end
    return tab;
  endfunction

  localparam logic [X_FRAC*32-1:0] C_TABLE = build_table();

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;

  logic [31:0]              m_reg;
  logic [X_FRAC-1:0]        frac_reg;
  logic signed [X_INT-1:0]  n_reg;
  logic [CNT_W-1:0]         iter_cnt;

  logic [31:0]              coef;
  logic [31:0]              m_mul;
  int                       shift_amt;
  int                       rsh;
  logic [WIDE_W-1:0]        wide_val;
  logic [63:0]              rnd_val;
  logic                     big_left;
  logic                     sat;
  logic [Y_WIDTH-1:0]       y_next;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. The block is idle-ready only; a new x
  // is never overlapped with a computation in flight.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = S_ITER;
        end
      end
      S_ITER: begin
        if (iter_cnt == CNT_W'(X_FRAC)) begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Selects C_i for the current iteration and forms the truncated product.
  // The 64-bit product of two values below 2^31 cannot overflow.
  always_comb begin
    coef = '0;
    for (int k = 1; k <= X_FRAC; k++) begin
      if (iter_cnt == CNT_W'(k)) begin
        coef = C_TABLE[(k-1)*32 +: 32];
      end
    end
    m_mul = 32'((64'(m_reg) * 64'(coef)) >> M_FRAC);
  end

  // Final scaling: y = m * 2^(n + Y_FRAC - 30). A non-negative shift moves
  // left (and can saturate); a negative shift moves right (and can round
  // or underflow to zero). Saturation is judged on the value after rounding.
  always_comb begin
    shift_amt = int'(n_reg) + Y_FRAC - M_FRAC;
    rsh       = 0;
    wide_val  = '0;
    rnd_val   = '0;
    big_left  = 1'b0;
    if (shift_amt >= 0) begin
      if (shift_amt >= 64) begin
        big_left = 1'b1;
      end else begin
        wide_val = WIDE_W'(m_reg) << shift_amt[5:0];
      end
    end else begin
      rsh = -shift_amt;
      if (rsh < 64) begin
`ifdef EXP2_ROUND_EN
        rnd_val = (64'(m_reg) + (64'd1 << (rsh[5:0] - 6'd1))) >> rsh[5:0];
`else
        rnd_val = 64'(m_reg) >> rsh[5:0];
`endif
        wide_val = WIDE_W'(rnd_val);
      end
    end
    sat    = big_left | (|wide_val[WIDE_W-1:Y_WIDTH]);
    y_next = sat ? '1 : wide_val[Y_WIDTH-1:0];
  end

  // Datapath registers. The fraction register shifts left every iteration
  // so the bit that belongs to iteration i always sits at the MSB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_reg    <= '0;
      frac_reg <= '0;
      n_reg    <= '0;
      iter_cnt <= '0;
      out_y    <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            frac_reg <= in_x[X_FRAC-1:0];
            n_reg    <= in_x[XW-1:X_FRAC];
            m_reg    <= M_ONE;
            iter_cnt <= CNT_W'(1);
          end
        end
        S_ITER: begin
          if (frac_reg[X_FRAC-1]) begin
            m_reg <= m_mul;
          end
          frac_reg <= frac_reg << 1;
          if (iter_cnt != CNT_W'(X_FRAC)) begin
            iter_cnt <= iter_cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          out_y   <= y_next;
          out_ovf <= sat;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp2_fixed.sv
// ---------------------------------------------------------------------------
// tb_exp2_fixed
//
// Self-checking bench for exp2_fixed at default parameters. A behavioural
// model derives each result from the arithmetic definition of 2^x (bit-true
// mantissa product and final scaling), and a real-valued 2**x gold value
// bounds the accuracy. Directed literal cases pin both the model and the DUT.
// Honours EXP2_ROUND_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exp2_fixed;

  localparam int X_INT   = 6;
  localparam int X_FRAC  = 16;
  localparam int Y_WIDTH = 32;
  localparam int Y_FRAC  = 16;
  localparam int XW      = X_INT + X_FRAC;
  localparam int LATENCY = X_FRAC + 1;
  localparam int N_RAND  = 1000;

  logic               clock;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [XW-1:0]      in_x;
  logic               out_valid;
  logic               out_ready;
  logic [Y_WIDTH-1:0] out_y;
  logic               out_ovf;

  int checks;
  int errors;

  typedef struct {
    logic [XW-1:0]      x;
    logic [Y_WIDTH-1:0] y;
    logic               ovf;
  } exp_t;

  exp_t exp_q[$];

  // Directed cases: 0, 1.0, -1.0, 0.5, 16.0, -20.0
  localparam logic [XW-1:0] DIR_X [6] = '{22'h000000, 22'h010000, 22'h3F0000,
                                          22'h008000, 22'h100000, 22'h2C0000};
`ifdef EXP2_ROUND_EN
  localparam logic [31:0] DIR_Y [6] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000,
                                        32'h0001_6A0A, 32'hFFFF_FFFF, 32'h0000_0000};
`else
  localparam logic [31:0] DIR_Y [6] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000,
                                        32'h0001_6A09, 32'hFFFF_FFFF, 32'h0000_0000};
`endif
  localparam logic DIR_O [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  exp2_fixed #(
    .X_INT  (X_INT),
    .X_FRAC (X_FRAC),
    .Y_WIDTH(Y_WIDTH),
    .Y_FRAC (Y_FRAC)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_ovf  (out_ovf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // round(2^(2^-i) * 2^30)
  function automatic longint unsigned c_const(input int i);
    real e;
    e = 1.0;
    for (int k = 0; k < i; k++) e = e / 2.0;
    return longint'($rtoi((2.0 ** e) * 1073741824.0 + 0.5));
  endfunction

  // Reference result for one x.
  function automatic void exp_model(input logic [XW-1:0] x,
                                    output logic [Y_WIDTH-1:0] y,
                                    output logic ovf);
    longint unsigned m;
    longint unsigned v;
    int              n;
    int              sh;
    int              r;
    n = int'($signed(x[XW-1:X_FRAC]));
    m = 64'd1 << 30;
    for (int i = 1; i <= X_FRAC; i++) begin
      if (x[X_FRAC-i]) m = (m * c_const(i)) >> 30;
    end
    sh = n + Y_FRAC - 30;
    if (sh >= 0) begin
      v = m << sh;
    end else begin
      r = -sh;
      if (r >= 64) v = 0;
`ifdef EXP2_ROUND_EN
      else v = (m + (64'd1 << (r - 1))) >> r;
`else
      else v = m >> r;
`endif
    end
    ovf = (v > 64'hFFFF_FFFF);
    y   = ovf ? '1 : v[Y_WIDTH-1:0];
  endfunction

  function automatic real gold(input logic [XW-1:0] x);
    real xr;
    xr = real'($signed(x)) / 65536.0;
    return (2.0 ** xr) * 65536.0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Presents x and holds it until accepted. Entered and left just after a
  // rising edge; optionally randomizes out_ready while waiting.
  task automatic applyStimulus(input logic [XW-1:0] x, input bit rnd_bp);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    in_x = x;
    in_valid = 1'b1;
    while (!done && t < 400) begin
      @(negedge clock);
      t++;
      if (in_ready) done = 1'b1;
      @(posedge clock);
      #1;
      if (done) in_valid = 1'b0;
      else if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(done), 64'd1);
  endtask

  // Waits for the result, checks it against literals, holds it for 'hold'
  // cycles with out_ready low, then takes it.
  task automatic getResult(input int hold, input logic [31:0] want_y, input logic want_ovf);
    int t;
    bit found;
    t = 0;
    found = 1'b0;
    out_ready = 1'b0;
    while (!found && t < 100) begin
      @(negedge clock);
      t++;
      if (out_valid) found = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    checkOutput("result_timeout", 64'(found), 64'd1);
    checkOutput("dir_y", 64'(out_y), 64'(want_y));
    checkOutput("dir_ovf", 64'(out_ovf), 64'(want_ovf));
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      checkOutput("hold_y", 64'(out_y), 64'(want_y));
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  // Compare process: snapshots pre-edge handshakes at the falling edge,
  // checks outputs against the scoreboard there, updates the scoreboard at
  // the following rising edge.
  initial begin : compare_proc
    bit               acc;
    bit               take;
    logic [31:0]      y_snap;
    logic             ovf_snap;
    int               lat;
    bit               lat_done;
    exp_t             e;
    int               sh;
    real              diff;
    real              extra;
    real              lo;
    real              hi;
    lat = 0;
    lat_done = 1'b0;
    forever begin
      @(negedge clock);
      acc      = reset_n && in_valid && in_ready;
      take     = reset_n && out_valid && out_ready;
      y_snap   = out_y;
      ovf_snap = out_ovf;
      if (reset_n) begin
        if (exp_q.size() == 0) begin
          checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
          checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
        end else begin
          checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
          if (out_valid) begin
            checkOutput("out_y", 64'(out_y), 64'(exp_q[0].y));
            checkOutput("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
            if (!lat_done) begin
              checkOutput("latency", 64'(lat), 64'(LATENCY));
              lat_done = 1'b1;
            end
          end else if (lat >= LATENCY) begin
            checkOutput("late_out_valid", 64'(out_valid), 64'd1);
          end
        end
      end
      @(posedge clock);
      if (!reset_n) begin
        exp_q.delete();
      end else begin
        if (take && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (!e.ovf) begin
            sh    = int'($signed(e.x[XW-1:X_FRAC])) + Y_FRAC - 30;
            extra = 64.0 * (2.0 ** real'(sh));
`ifdef EXP2_ROUND_EN
            lo = -1.0;
            hi = 1.0;
`else
            lo = -2.0;
            hi = 0.0;
`endif
            diff = real'(y_snap) - gold(e.x);
            checks++;
            if (diff < lo - extra || diff > hi + extra) begin
              errors++;
              $display("[TB] FAIL gold x=%0h got=%0h gold=%f", e.x, y_snap, gold(e.x));
            end
          end else begin
            checkOutput("gold_ovf", 64'(ovf_snap), 64'd1);
          end
        end
        if (acc) begin
          e.x = in_x;
          exp_model(in_x, e.y, e.ovf);
          exp_q.push_back(e);
          lat = 0;
          lat_done = 1'b0;
        end else if (exp_q.size() != 0) begin
          lat++;
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main_proc
    logic [31:0] my;
    logic        mo;
    int          t;
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;

    // Model pins against hand-computed values.
    for (int k = 0; k < 6; k++) begin
      exp_model(DIR_X[k], my, mo);
      checkOutput("model_pin_y", 64'(my), 64'(DIR_Y[k]));
      checkOutput("model_pin_ovf", 64'(mo), 64'(DIR_O[k]));
    end

    // Reset values.
    @(negedge clock);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_y", 64'(out_y), 64'd0);
    checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] directed cases");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(DIR_X[k], 1'b0);
      getResult((k == 0) ? 10 : 0, DIR_Y[k], DIR_O[k]);
    end

    $display("[TB] reset during iteration 8");
    applyStimulus(22'h012345, 1'b0);
    repeat (7) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (25) @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("post_abort_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;

    $display("[TB] random sweep with back-pressure");
    for (int k = 0; k < N_RAND; k++) begin
      applyStimulus(XW'(int'($urandom_range(0, 32*65536 - 1)) - 16*65536), 1'b1);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clock);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    out_ready = 1'b0;
    checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp2_fixed.md
# exp2_fixed

Sequential fixed-point base-2 exponentiator: computes y = 2^x for a signed fixed-point x with one constant multiply per fractional input bit. It is the inverse of the log2 function used in our VPI math checks. It is synthesizable, uses valid/ready streams on both sides, and its results are checked in utest benches against the real-valued gold model (2 ** x).

## Interface
- X_INT, 6: signed integer bits of x, sign included.
- X_FRAC, 16: fractional bits of x; also the iteration count.
- Y_WIDTH, 32: output width, unsigned.
- Y_FRAC, 16: output fractional bits.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  x is valid.
- in_ready  out  1  block accepts x; high only in IDLE.
- in_x  in  X_INT+X_FRAC  signed x in Q(X_INT).(X_FRAC) two's complement.
- out_valid  out  1  result is valid; held until taken.
- out_ready  in  1  consumer takes the result.
- out_y  out  Y_WIDTH  unsigned y in Q(Y_WIDTH-Y_FRAC).(Y_FRAC).
- out_ovf  out  1  result saturated; qualified by out_valid.

## Operation
- Split x: the integer part n = floor(x) is signed (arithmetic upper bits). The fraction f is the low X_FRAC bits and is always ≥ 0.
- Mantissa m: unsigned, 32 bits, Q2.30. Set to 1.0 (0x4000_0000) on accept.
- Constant table C_i = round(2^(2^-i) · 2^30), for i = 1..X_FRAC. Computed at elaboration in a constant function using real math, so there are no hand-entered values.
- Iteration i (one per clock): if bit (X_FRAC-i) of f is set, m ← (m · C_i) >> 30 using a 64-bit product, truncated. Otherwise m is unchanged. m stays within [1.0, 2.0).
- Final shift: y = m · 2^n, rescaled from 30 to Y_FRAC fractional bits.
  - Left shift by n when n ≥ 0.
  - Right shift by -n when n < 0. Shift amounts ≥ 64 yield 0.
- Saturation: if the shifted value exceeds 2^Y_WIDTH-1:
  - out_y = all ones and out_ovf = 1.
  - Otherwise out_ovf = 0.
- Underflow (value < 1 LSB after the shift/round) returns 0 with out_ovf = 0.
- State machine:
  - IDLE → ITER on in_valid & in_ready. Latch f and n, set m = 1.0, set i = 1.
  - ITER → ITER while i < X_FRAC (i increments each cycle).
  - ITER → SHIFT after iteration X_FRAC.
  - SHIFT → DONE: register out_y and out_ovf.
  - DONE → IDLE on out_ready.
- out_y and out_ovf stay stable from entry to DONE until the handshake completes.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_y 0, out_ovf 0, m 0, i 0.
- The input is accepted at edge E0. Iterations run on edges E1..E(X_FRAC). out_y is registered at E(X_FRAC+1).
- out_valid is high from E(X_FRAC+1) onward. Latency is X_FRAC+1 cycles from accept to out_valid.
- If out_ready is already high when out_valid rises, the output is taken at the next edge and in_ready is high the cycle after that.
- Minimum spacing between accepted inputs is X_FRAC+3 cycles.
- in_valid while busy is ignored; the source holds x until in_ready.
- out_ready while out_valid=0 has no effect.
- Reset assertion mid-operation aborts immediately to reset values. No result is produced for the aborted input.

## Configuration
- EXP2_ROUND_EN defined: the final right shift rounds half-up, adding 1 at the first discarded bit before truncation. Saturation is checked after rounding.
- EXP2_ROUND_EN undefined: the final shift truncates (floor).
- Iterations always truncate in both builds.
- Accuracy, at default parameters against the gold model:
  - With EXP2_ROUND_EN: within ±1 LSB.
  - Without EXP2_ROUND_EN: within -2..0 LSB.

## Test plan
Defaults for all scenarios: X_FRAC=16, Y_FRAC=16, Y_WIDTH=32.
- x=0 (0x000000) → out_y=0x0001_0000, out_ovf=0, out_valid exactly 17 cycles after accept.
- x=1.0 (0x010000) → 0x0002_0000. x=-1.0 → 0x0000_8000. Both results exact, in both builds.
- x=0.5 (0x008000) → 0x0001_6A0A with EXP2_ROUND_EN, 0x0001_6A09 without (±1 LSB allowed).
- Saturation and underflow:
  - x=16.0 → 0xFFFF_FFFF, out_ovf=1.
  - x=-20.0 → 0x0000_0000, out_ovf=0.
- Handshake and reset:
  - Hold out_ready low for 10 cycles: out_y stays stable and in_ready stays 0.
  - Pulse reset_n low at iteration 8: out_valid stays 0 and in_ready returns to 1.
- Random sweep of 1000 x values in [-16, 15.99]: compare against the real gold model using the build's LSB tolerance. Use random out_ready back-pressure. Log any mismatch as an error.
